// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit scan controller arbitrating between two 16-bit sources, with frame-atomic snapshots.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module display_scan_controller #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a_data,
  input  logic        b_req,
  input  logic [15:0] b_data,
  output logic [3:0]  cathode,
  output logic [3:0]  digit_data,
  output logic        blank,
  output logic        owner,
  output logic        frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic {SHOW_A = 1'b0, SHOW_B = 1'b1} state_t;

  logic [PW-1:0] prescaler;
  logic [1:0]    idx, idx_nxt;
  state_t        state, state_nxt;
  logic          pending, pending_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [15:0]   frame_q, frame_nxt;
  logic          scan_tick, boundary, req_eff;
  logic [3:0]    cathode_nxt, digit_nxt;
  logic          blank_nxt;

  assign scan_tick = (prescaler == PW'(SCAN_DIV - 1));
  assign boundary  = scan_tick && (idx == 2'd3);
  assign req_eff   = pending | b_req;
  assign owner     = (state == SHOW_B);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | b_req;
    hold_nxt    = hold;
    frame_nxt   = frame_q;
    idx_nxt     = scan_tick ? idx + 2'd1 : idx;
    if (boundary) begin
      case (state)
        SHOW_A: begin
          if (req_eff) begin
            state_nxt   = SHOW_B;
            pending_nxt = 1'b0;
            hold_nxt    = HW'(HOLD_FRAMES - 1);
            frame_nxt   = b_data;
          end else begin
            frame_nxt = a_data;
          end
        end
        SHOW_B: begin
          if (hold != '0) begin
            hold_nxt  = hold - HW'(1);
            frame_nxt = b_data;
          end else if (req_eff) begin
            pending_nxt = 1'b0;
            hold_nxt    = HW'(HOLD_FRAMES - 1);
            frame_nxt   = b_data;
          end else begin
            state_nxt = SHOW_A;
            frame_nxt = a_data;
          end
        end
        default: state_nxt = SHOW_A;
      endcase
    end
  end

  // Output stage looks ahead at the next digit and the freshly snapshotted frame.
  always_comb begin
    cathode_nxt = 4'b1111;
    digit_nxt   = 4'h0;
    blank_nxt   = 1'b0;
    case (idx_nxt)
      2'd0: begin cathode_nxt = 4'b0111; digit_nxt = frame_nxt[15:12]; end
      2'd1: begin cathode_nxt = 4'b1011; digit_nxt = frame_nxt[11:8];  end
      2'd2: begin cathode_nxt = 4'b1101; digit_nxt = frame_nxt[7:4];   end
      default: begin cathode_nxt = 4'b1110; digit_nxt = frame_nxt[3:0]; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_nxt)
      2'd0:    blank_nxt = (frame_nxt[15:12] == 4'h0);
      2'd1:    blank_nxt = (frame_nxt[15:8] == 8'h00);
      2'd2:    blank_nxt = (frame_nxt[15:4] == 12'h000);
      default: blank_nxt = 1'b0;
    endcase
`else
    blank_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      idx        <= 2'd3;
      state      <= SHOW_A;
      pending    <= 1'b0;
      hold       <= '0;
      frame_q    <= 16'h0000;
      cathode    <= 4'b1111;
      digit_data <= 4'h0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      prescaler  <= scan_tick ? '0 : prescaler + PW'(1);
      idx        <= idx_nxt;
      state      <= state_nxt;
      pending    <= pending_nxt;
      hold       <= hold_nxt;
      frame_q    <= frame_nxt;
      frame_tick <= boundary;
      if (scan_tick) begin
        cathode    <= cathode_nxt;
        digit_data <= digit_nxt;
        blank      <= blank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller against a slot/frame-level reference model.
module tb_display_scan_controller;

  localparam int SCAN_DIV    = 4;
  localparam int HOLD_FRAMES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a_data = 16'h0000;
  logic        b_req = 1'b0;
  logic [15:0] b_data = 16'h0000;
  logic [3:0]  cathode, digit_data;
  logic        blank, owner, frame_tick;

  display_scan_controller #(.SCAN_DIV(SCAN_DIV), .HOLD_FRAMES(HOLD_FRAMES)) dut (
    .clk(clk), .reset(reset), .a_data(a_data), .b_req(b_req), .b_data(b_data),
    .cathode(cathode), .digit_data(digit_data), .blank(blank), .owner(owner),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: cycles since reset, slots shown, owner and remaining frames of B.
  int          m_cnt, m_ticks, m_frames_left;
  logic        m_owner, m_req;
  logic [15:0] m_frame;
  logic [3:0]  e_cath, e_dig;
  logic        e_blank, e_ft;
  logic [10:0] exp_v;
  wire  [10:0] got_v = {cathode, digit_data, blank, owner, frame_tick};

  task automatic cyc();
    int slot;
    logic req_now;
    if (reset) begin
      m_cnt = 0; m_ticks = 0; m_owner = 1'b0; m_req = 1'b0; m_frame = 16'h0;
      m_frames_left = 0;
      e_cath = 4'b1111; e_dig = 4'h0; e_blank = 1'b1; e_ft = 1'b0;
    end else begin
      e_ft    = 1'b0;
      req_now = m_req | b_req;
      m_req   = req_now;
      if (m_cnt % SCAN_DIV == SCAN_DIV - 1) begin
        slot = m_ticks % 4;
        m_ticks++;
        if (slot == 0) begin
          e_ft = 1'b1;
          if (!m_owner) begin
            if (req_now) begin m_owner = 1'b1; m_frames_left = HOLD_FRAMES; m_req = 1'b0; end
          end else if (m_frames_left > 1) begin
            m_frames_left--;
          end else if (req_now) begin
            m_frames_left = HOLD_FRAMES; m_req = 1'b0;
          end else begin
            m_owner = 1'b0;
          end
          m_frame = m_owner ? b_data : a_data;
        end
        e_cath = ~(4'b1000 >> slot);
        e_dig  = 4'((m_frame >> (4 * (3 - slot))) & 16'hf);
        e_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot < 3) e_blank = ((m_frame >> (4 * (3 - slot))) == 16'h0);
`endif
      end
      m_cnt++;
    end
    exp_v = {e_cath, e_dig, e_blank, m_owner, e_ft};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = 16'($urandom); b_data = 16'($urandom); b_req = 1'($urandom);
      cyc();
      compared++;
      if (got_v !== exp_v) begin mismatched++; $display("FAIL reset_model got=%h exp=%h", got_v, exp_v); end
    end
    compared++;
    if ({cathode, digit_data, blank, owner, frame_tick} !== {4'b1111, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_values got=%b%h%b%b%b exp=1111 0 1 0 0", cathode, digit_data, blank, owner, frame_tick);
    end
    b_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_scan_basic();
    logic [3:0] cs [16];
    logic [3:0] ds [16];
    int n = -1;
    int ft_cnt = 0;
    test_reset();
    a_data = 16'h1234;
    for (int i = 0; i < 48; i++) begin
      cyc();
      compared++;
      if (got_v !== exp_v) begin mismatched++; $display("FAIL scan_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
      if (frame_tick) ft_cnt++;
      if (frame_tick && n < 0) n = 0;
      if (n >= 0 && n < 16) begin cs[n] = cathode; ds[n] = digit_data; n++; end
    end
    compared++;
    if (ft_cnt != 3) begin mismatched++; $display("FAIL scan_frame_ticks got=%0d exp=3", ft_cnt); end
    for (int k = 0; k < 16; k++) begin
      compared++;
      if (cs[k] !== ~(4'b1000 >> (k / 4)) || ds[k] !== 4'(k / 4 + 1)) begin
        mismatched++;
        $display("FAIL scan_sequence k=%0d got=%b/%h exp=%b/%h", k, cs[k], ds[k], ~(4'b1000 >> (k / 4)), 4'(k / 4 + 1));
      end
    end
  endtask

  task automatic test_mid_frame_change();
    test_reset();
    a_data = 16'h5678;
    for (int i = 0; i < 60; i++) begin
      if (i == 25 + int'($urandom_range(0, 6))) a_data = 16'h9ABC;
      cyc();
      compared++;
      if (got_v !== exp_v) begin mismatched++; $display("FAIL midframe_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
      if (i == 34) begin
        compared++;
        if (digit_data !== 4'h8) begin mismatched++; $display("FAIL midframe_hold got=%h exp=8", digit_data); end
      end
    end
  endtask

  task automatic test_b_pulse();
    int b_frames = 0;
    test_reset();
    a_data = 16'($urandom); b_data = 16'h0BAD;
    for (int i = 0; i < 100; i++) begin
      b_req = (i == 26);
      cyc();
      compared++;
      if (got_v !== exp_v) begin mismatched++; $display("FAIL bpulse_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
      if (frame_tick && owner) begin
        b_frames++;
        compared++;
        if (digit_data !== 4'h0) begin mismatched++; $display("FAIL bpulse_first_digit got=%h exp=0", digit_data); end
      end
    end
    compared++;
    if (b_frames != 2) begin mismatched++; $display("FAIL bpulse_frames got=%0d exp=2", b_frames); end
    compared++;
    if (owner !== 1'b0) begin mismatched++; $display("FAIL bpulse_return got=%b exp=0", owner); end
  endtask

  task automatic test_b_held();
    int rel;
    test_reset();
    a_data = 16'($urandom); b_data = 16'($urandom);
    rel = 30 + int'($urandom_range(0, 60));
    for (int i = 0; i < 200; i++) begin
      b_req = (i >= 5 && i < rel);
      cyc();
      compared++;
      if (got_v !== exp_v) begin mismatched++; $display("FAIL bheld_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
      if (i > 30 && i < rel) begin
        compared++;
        if (owner !== 1'b1) begin mismatched++; $display("FAIL bheld_owner cyc=%0d got=%b exp=1", i, owner); end
      end
    end
    compared++;
    if (owner !== 1'b0) begin mismatched++; $display("FAIL bheld_release got=%b exp=0", owner); end
  endtask

  task automatic test_leading_zero();
    logic [15:0] pats [3] = '{16'h0007, 16'h0000, 16'h0050};
    for (int p = 0; p < 3; p++) begin
      test_reset();
      a_data = pats[p];
      for (int i = 0; i < 40; i++) begin
        cyc();
        compared++;
        if (got_v !== exp_v) begin mismatched++; $display("FAIL lzb_model pat=%h cyc=%0d got=%h exp=%h", pats[p], i, got_v, exp_v); end
        if (i >= 4 && cathode == 4'b1110) begin
          compared++;
          if (blank !== 1'b0) begin mismatched++; $display("FAIL lzb_ones got=%b exp=0", blank); end
        end
      end
    end
  endtask

  task automatic test_reset_in_b();
    test_reset();
    a_data = 16'h1111; b_data = 16'h2222;
    for (int i = 0; i < 30; i++) begin
      b_req = (i == 10 || i == 24);
      cyc();
      compared++;
      if (got_v !== exp_v) begin mismatched++; $display("FAIL rstb_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
    end
    compared++;
    if (owner !== 1'b1) begin mismatched++; $display("FAIL rstb_in_b got=%b exp=1", owner); end
    reset = 1'b1; b_req = 1'b0;
    cyc();
    compared++;
    if ({owner, cathode, blank} !== {1'b0, 4'b1111, 1'b1}) begin
      mismatched++; $display("FAIL rstb_after got=%b/%b/%b exp=0/1111/1", owner, cathode, blank);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      compared++;
      if (got_v !== exp_v || owner !== 1'b0) begin
        mismatched++; $display("FAIL rstb_lost cyc=%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    test_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) a_data = 16'($urandom);
      if ($urandom_range(0, 19) == 0) b_data = 16'($urandom);
      b_req = ($urandom_range(0, 59) == 0);
      reset = ($urandom_range(0, 399) == 0);
      cyc();
      compared++;
      if (got_v !== exp_v) begin mismatched++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, got_v, exp_v); end
    end
    reset = 1'b0; b_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_mid_frame_change();
    test_b_pulse();
    test_b_held();
    test_leading_zero();
    test_reset_in_b();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, giving clk cycles per digit slot; legal values are at least 2.
REQ-002 SHALL have parameter HOLD_FRAMES, default 250, giving the minimum number of frames source B owns the display once granted; legal values are at least 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port a_data, input, 16 bits: primary source; nibbles [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-006 SHALL have port b_req, input, 1 bit: secondary-source display request; a single-cycle pulse is sufficient.
REQ-007 SHALL have port b_data, input, 16 bits: secondary source, same nibble order as a_data.
REQ-008 SHALL have port cathode, output, 4 bits: one-cold active-low digit select; bit3 is thousands, bit0 is ones.
REQ-009 SHALL have port digit_data, output, 4 bits: nibble for the active digit, sent to the digit decoder.
REQ-010 SHALL have port blank, output, 1 bit: high forces the active digit's segments off downstream.
REQ-011 SHALL have port owner, output, 1 bit: 0 = source A displayed, 1 = source B displayed.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL count a prescaler 0..SCAN_DIV-1, wrapping to 0; scan_tick is asserted internally in the cycle the prescaler equals SCAN_DIV-1.
REQ-014 SHALL advance digit index idx (0 = thousands .. 3 = ones) on each scan_tick, wrapping 3 to 0; the 3-to-0 wrap is the frame boundary.
REQ-015 SHALL register cathode, digit_data, blank and frame_tick so they update on the clock edge at the end of the scan_tick cycle, one cycle of latency, and hold until the next scan_tick.
REQ-016 SHALL drive cathode with idx0 = 4'b0111, idx1 = 4'b1011, idx2 = 4'b1101, idx3 = 4'b1110.
REQ-017 SHALL, at each frame boundary, snapshot the owning source's 16-bit data into a frame register; digit_data SHALL come only from the frame register, so the display cannot tear mid-frame.
REQ-018 SHALL implement arbitration states SHOW_A and SHOW_B; owner reflects the state.
REQ-019 SHALL set a pending flag on any cycle with b_req=1, while in either state.
REQ-020 SHALL, in SHOW_A at a frame boundary with pending=1, go to SHOW_B, clear pending, load hold to HOLD_FRAMES-1, and snapshot b_data (not a_data) at that same boundary.
REQ-021 SHALL, in SHOW_B at a frame boundary: if hold>0, decrement hold; else if pending=1 or b_req=1, stay, clear pending and reload hold to HOLD_FRAMES-1; else go to SHOW_A and snapshot a_data.
REQ-022 SHALL give b_req asserted in the same cycle as a frame boundary the effect of pending=1 at that boundary.
REQ-023 SHALL keep blank=0 for all digits when the configuration feature is absent.

Reset
REQ-024 SHALL, on reset=1, set prescaler=0, idx=3, state=SHOW_A, pending=0, hold=0 and frame register=0.
REQ-025 SHALL, on reset=1, set cathode=4'b1111, digit_data=0, blank=1, owner=0 and frame_tick=0.
REQ-026 SHALL let the first scan_tick after reset be a frame boundary that loads a_data (or b_data if pending) and selects idx0.
REQ-027 SHALL abandon any in-progress hold or pending request when reset is asserted mid-operation.

Configuration
REQ-028 SHALL, with macro LEADING_ZERO_BLANK_EN defined, assert blank for digit idx when its frame nibble and all more-significant frame nibbles are 0; the ones digit is never blanked.
REQ-029 SHALL, without LEADING_ZERO_BLANK_EN, omit the blanking logic and hold blank=0 after reset.

Verification (SCAN_DIV=4, HOLD_FRAMES=2)
REQ-030 SHALL cover: reset, then a_data=16'h1234 -> cathode sequence 0111/1011/1101/1110 with digit_data 1,2,3,4, each held 4 cycles, and frame_tick pulsing once per 16 cycles.
REQ-031 SHALL cover: a_data changes mid-frame -> the displayed nibbles do not change until the next frame boundary.
REQ-032 SHALL cover: 1-cycle b_req pulse mid-frame, b_data=16'h0BAD -> owner=1 from the next boundary for exactly 2 frames showing 0,B,A,D, then owner=0.
REQ-033 SHALL cover: b_req held high -> owner stays 1; after release, owner returns to 0 at the first boundary after hold expires.
REQ-034 SHALL cover: with LEADING_ZERO_BLANK_EN, a_data=16'h0007 -> blank=1 on idx0..2 and 0 on idx3; a_data=0 -> only the ones digit is unblanked; without the macro, blank=0 throughout.
REQ-035 SHALL cover: reset asserted during SHOW_B -> next cycle owner=0, cathode=4'b1111, blank=1, and the pending request is lost.
